// File: rtl/i2c_target_core.sv
// rtl/i2c_target_core.sv - I2C target core; optional SCL stretching on received bytes under I2C_TARGET_STRETCH_EN
//
// SCL/SDA are synchronised and filtered on clk. START, repeated START and STOP are decoded from the
// filtered lines. Write bytes are presented on rx_data/rx_valid. Read bytes are fetched from tx_data
// with a tx_req strobe. SDA is only ever pulled low (sda_oe); the pad itself is open-drain.
// With I2C_TARGET_STRETCH_EN defined, the core holds SCL low after a write byte until rx_ready accepts it.

module i2c_target_core #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
`ifdef I2C_TARGET_STRETCH_EN
    output logic       scl_oe,
    input  logic       rx_ready,
`endif
    output logic       active
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_RD_DATA  = 3'd4;
    localparam logic [2:0] S_RD_ACK   = 3'd5;
    localparam logic [2:0] S_IGNORE   = 3'd6;

    // A filtered level flips once the synchronised input has disagreed for FILT_LEN samples in a row.
    localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic [2:0] r_scl_cnt;
    logic [2:0] r_sda_cnt;
    logic       r_scl_filt;
    logic       r_sda_filt;
    logic       r_scl_prev;
    logic       r_sda_prev;

    logic [2:0] r_state;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_sda_oe;
    logic       r_rw;
    logic       r_active;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
`ifdef I2C_TARGET_STRETCH_EN
    logic       r_scl_oe;
`endif

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    // Two-flop synchronisers; idle bus level is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
        end
    end

    // SCL stability filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_filt <= 1'b1;
            r_scl_cnt  <= 3'd0;
        end else if (r_scl_sync[1] != r_scl_filt) begin
            if (r_scl_cnt == FILT_MAX) begin
                r_scl_filt <= r_scl_sync[1];
                r_scl_cnt  <= 3'd0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 3'd1;
            end
        end else begin
            r_scl_cnt <= 3'd0;
        end
    end

    // SDA stability filter; identical to SCL so both lines see the same lag and keep their ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_filt <= 1'b1;
            r_sda_cnt  <= 3'd0;
        end else if (r_sda_sync[1] != r_sda_filt) begin
            if (r_sda_cnt == FILT_MAX) begin
                r_sda_filt <= r_sda_sync[1];
                r_sda_cnt  <= 3'd0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 3'd1;
            end
        end else begin
            r_sda_cnt <= 3'd0;
        end
    end

    // Previous filtered levels for one-clk edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    // START/STOP require SCL high on both sides of the SDA edge, so an SDA change coincident
    // with an SCL edge is never mistaken for a bus condition.
    assign w_scl_rise = r_scl_filt & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_filt & r_scl_prev;
    assign w_start    = r_sda_prev & ~r_sda_filt & r_scl_filt & r_scl_prev;
    assign w_stop     = ~r_sda_prev & r_sda_filt & r_scl_filt & r_scl_prev;
    assign w_sda      = r_sda_filt;

    // Protocol FSM: bus conditions first, then per-state bit handling on filtered SCL edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_rw       <= 1'b0;
            r_active   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            r_scl_oe   <= 1'b0;
`endif
        end else begin
            r_tx_req <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            // rx_valid is held until accepted; accepting while SCL is stretched drives the ACK
            // and lets SCL go in the same clk.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
                if (r_scl_oe) begin
                    r_scl_oe <= 1'b0;
                    r_sda_oe <= 1'b1;
                end
            end
`else
            r_rx_valid <= 1'b0;
`endif
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_active <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                r_rx_valid <= 1'b0;
                r_scl_oe   <= 1'b0;
`endif
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_active <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                r_rx_valid <= 1'b0;
                r_scl_oe   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= {r_shift[6:0], w_sda};
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= 4'd8;
                                // r_shift[6:0] already holds address bits 7..1; w_sda is R/W.
                                if (r_shift[6:0] == TARGET_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_sda;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        // First fall drives the ACK, the second one ends the ACK slot.
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                                r_active <= 1'b1;
                            end else if (!r_rw) begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd0;
                                r_state  <= S_WR_DATA;
                            end else begin
                                r_tx_req <= 1'b1;
                                r_shift  <= tx_data;
                                r_sda_oe <= ~tx_data[7];
                                r_bitcnt <= 4'd0;
                                r_state  <= S_RD_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (r_bitcnt != 4'd8) begin
                            if (w_scl_rise) begin
                                r_shift <= {r_shift[6:0], w_sda};
                                if (r_bitcnt == 4'd7) begin
                                    r_rx_data  <= {r_shift[6:0], w_sda};
                                    r_rx_valid <= 1'b1;
                                    r_bitcnt   <= 4'd8;
                                end else begin
                                    r_bitcnt <= r_bitcnt + 4'd1;
                                end
                            end
                        end else if (w_scl_fall) begin
                            if (!r_sda_oe) begin
`ifdef I2C_TARGET_STRETCH_EN
                                if (r_rx_valid && !rx_ready) begin
                                    r_scl_oe <= 1'b1;
                                end else begin
                                    r_sda_oe <= 1'b1;
                                end
`else
                                r_sda_oe <= 1'b1;
`endif
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd0;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        // r_bitcnt counts bits the master has sampled; bit 7 was driven on entry.
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        // r_bitcnt is 8 on entry and cleared when the master ACKs, marking a
                        // pending reload for the next fall.
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state  <= S_IGNORE;
                                r_active <= 1'b0;
                            end else begin
                                r_bitcnt <= 4'd0;
                            end
                        end else if (w_scl_fall && (r_bitcnt == 4'd0)) begin
                            r_tx_req <= 1'b1;
                            r_shift  <= tx_data;
                            r_sda_oe <= ~tx_data[7];
                            r_state  <= S_RD_DATA;
                        end
                    end
                    S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign rw       = r_rw;
    assign active   = r_active;
`ifdef I2C_TARGET_STRETCH_EN
    assign scl_oe   = r_scl_oe;
`endif

endmodule

// File: tb/tb_i2c_target_core.sv
// tb/tb_i2c_target_core.sv - self-checking bench for i2c_target_core
`timescale 1ns/1ps

module tb_i2c_target_core;

    localparam int Q = 25;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        logic       ack;
    } wr_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       rw;
    logic       active;
    logic       scl_oe;
`ifdef I2C_TARGET_STRETCH_EN
    logic       rx_ready;
`else
    assign scl_oe = 1'b0;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_txreq  = 0;
    logic       saw_oe   = 1'b0;
    logic       prev_rxv = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    always #50 clk = ~clk;

    assign scl_i = m_scl & ~scl_oe;
    assign sda_i = m_sda & ~sda_oe;

    i2c_target_core #(.TARGET_ADDR(7'h50), .FILT_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rw       (rw),
`ifdef I2C_TARGET_STRETCH_EN
        .scl_oe   (scl_oe),
        .rx_ready (rx_ready),
`endif
        .active   (active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rx_valid && !prev_rxv) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got rx_data %0h, expected no byte", rx_data);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
`ifndef I2C_TARGET_STRETCH_EN
        if (rx_valid && prev_rxv) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_valid_width: got high 2+ clk, expected 1 clk strobe");
        end
`endif
        prev_rxv = rx_valid;
        if (tx_req) n_txreq++;
        if (sda_oe) saw_oe = 1'b1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_scl_high();
        int t;
        t = 0;
        while (scl_i !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL scl_timeout: got SCL held low 2000 clk, expected release");
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clk(Q);
        b = sda_i;    wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_bits(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish within 10 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t    vec[6];
        logic       ack;
        logic [7:0] got;
        logic [7:0] d;
        logic       ok;

        vec[0] = '{8'hA0, 8'hA5, 8'h3C, 2, 1'b1};
        vec[1] = '{8'hA2, 8'h11, 8'h22, 2, 1'b0};
        vec[2] = '{8'h00, 8'h55, 8'h00, 1, 1'b0};
        vec[3] = '{8'hA0, 8'hFF, 8'h01, 2, 1'b1};
        vec[4] = '{8'hA0, 8'h00, 8'h80, 2, 1'b1};
        vec[5] = '{8'h20, 8'h01, 8'h00, 1, 1'b0};

        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        rst_n   = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
        rx_ready = 1'b1;
`endif
        wait_clk(5);
        chk("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data",  {24'd0, rx_data},  32'd0);
        chk("rst_tx_req",   {31'd0, tx_req},   32'd0);
        chk("rst_rw",       {31'd0, rw},       32'd0);
        chk("rst_active",   {31'd0, active},   32'd0);
`ifdef I2C_TARGET_STRETCH_EN
        chk("rst_scl_oe",   {31'd0, scl_oe},   32'd0);
`endif
        rst_n = 1'b1;
        wait_clk(10);

        // Write frames from the table: matched address ACKs everything, others stay silent.
        for (int v = 0; v < 6; v++) begin
            saw_oe = 1'b0;
            bus_start();
            send_byte(vec[v].addr, ack);
            chk($sformatf("addr_ack[%0d]", v), {31'd0, ack}, vec[v].ack ? 32'd0 : 32'd1);
            chk($sformatf("active_after_addr[%0d]", v), {31'd0, active}, {31'd0, vec[v].ack});
            if (vec[v].ack) chk($sformatf("rw_write[%0d]", v), {31'd0, rw}, 32'd0);
            for (int j = 0; j < vec[v].n; j++) begin
                d = (j == 0) ? vec[v].d0 : vec[v].d1;
                if (vec[v].ack) exp_rx.push_back(d);
                send_byte(d, ack);
                chk($sformatf("data_ack[%0d.%0d]", v, j), {31'd0, ack}, vec[v].ack ? 32'd0 : 32'd1);
            end
            bus_stop();
            chk($sformatf("active_after_stop[%0d]", v), {31'd0, active}, 32'd0);
            chk($sformatf("sda_driven[%0d]", v), {31'd0, saw_oe}, {31'd0, vec[v].ack});
            chk($sformatf("rx_pending[%0d]", v), exp_rx.size(), 32'd0);
        end

        // Read 0x96 then 0x0F, master ACK then NACK.
        n_txreq = 0;
        tx_data = 8'h96;
        exp_tx.push_back(tx_data);
        bus_start();
        send_byte(8'hA1, ack);
        chk("rd_addr_ack", {31'd0, ack}, 32'd0);
        chk("rd_rw", {31'd0, rw}, 32'd1);
        chk("rd_active", {31'd0, active}, 32'd1);
        recv_bits(got);
        chk("rd_byte0", {24'd0, got}, {24'd0, exp_tx.pop_front()});
        tx_data = 8'h0F;
        exp_tx.push_back(tx_data);
        send_bit(1'b0);
        recv_bits(got);
        chk("rd_byte1", {24'd0, got}, {24'd0, exp_tx.pop_front()});
        send_bit(1'b1);
        wait_clk(10);
        chk("rd_nack_active", {31'd0, active}, 32'd0);
        chk("rd_nack_sda_oe", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        chk("rd_tx_req_count", n_txreq, 32'd2);

        // Write 0x11, repeated START, read one byte.
        n_txreq = 0;
        bus_start();
        send_byte(8'hA0, ack);
        chk("rs_wr_ack", {31'd0, ack}, 32'd0);
        chk("rs_rw0", {31'd0, rw}, 32'd0);
        exp_rx.push_back(8'h11);
        send_byte(8'h11, ack);
        chk("rs_data_ack", {31'd0, ack}, 32'd0);
        bus_start();
        tx_data = 8'h5A;
        exp_tx.push_back(tx_data);
        send_byte(8'hA1, ack);
        chk("rs_rd_ack", {31'd0, ack}, 32'd0);
        chk("rs_rw1", {31'd0, rw}, 32'd1);
        recv_bits(got);
        chk("rs_rd_byte", {24'd0, got}, {24'd0, exp_tx.pop_front()});
        send_bit(1'b1);
        bus_stop();
        chk("rs_tx_req_count", n_txreq, 32'd1);
        chk("rs_rx_pending", exp_rx.size(), 32'd0);

        // 2-clk SDA glitch with SCL high: no START, so a following address is ignored.
        saw_oe = 1'b0;
        m_sda = 1'b0; wait_clk(2);
        m_sda = 1'b1; wait_clk(20);
        m_scl = 1'b0; wait_clk(Q);
        send_byte(8'hA0, ack);
        chk("glitch2_no_ack", {31'd0, ack}, 32'd1);
        chk("glitch2_no_drive", {31'd0, saw_oe}, 32'd0);
        bus_stop();

        // 4-clk SDA low with SCL high before SCL falls: recognised as START.
        m_sda = 1'b0; wait_clk(4);
        m_scl = 1'b0; wait_clk(Q);
        send_byte(8'hA0, ack);
        chk("glitch4_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'h42);
        send_byte(8'h42, ack);
        chk("glitch4_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();

        // Reset during the address ACK releases SDA at once; the rest of the frame is ignored.
        bus_start();
        d = 8'hA0;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        chk("ack_before_reset", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_async_release", {31'd0, sda_oe}, 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
        send_byte(8'h3C, ack);
        chk("post_reset_no_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        chk("post_reset_active", {31'd0, active}, 32'd0);
        bus_start();
        send_byte(8'hA0, ack);
        chk("recover_ack", {31'd0, ack}, 32'd0);
        exp_rx.push_back(8'h77);
        send_byte(8'h77, ack);
        chk("recover_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();

`ifdef I2C_TARGET_STRETCH_EN
        // Hold rx_ready low: SCL stays stretched with rx_valid high until acceptance.
        rx_ready = 1'b0;
        bus_start();
        send_byte(8'hA0, ack);
        chk("st_addr_ack", {31'd0, ack}, 32'd0);
        d = 8'h7E;
        exp_rx.push_back(d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!(scl_oe && rx_valid)) ok = 1'b0;
        end
        chk("st_hold_40clk", {31'd0, ok}, 32'd1);
        chk("st_no_ack_yet", {31'd0, sda_oe}, 32'd0);
        rx_ready = 1'b1;
        tick();
        chk("st_scl_release", {31'd0, scl_oe}, 32'd0);
        chk("st_ack_drive", {31'd0, sda_oe}, 32'd1);
        chk("st_rx_valid_clear", {31'd0, rx_valid}, 32'd0);
        recv_bit(ack);
        chk("st_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
`endif

        wait_clk(20);
        chk("final_rx_pending", exp_rx.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
